// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared RAM handshake and arbiter state types
// Also holds the arbitration priority rule so every user applies it identically.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IACC = 2'd1,
        ARB_DACC = 2'd2
    } arb_state_t;

    localparam int CNT_W = 4;

    // Data wins unless the instruction side has been starved
    function automatic arb_state_t arb_pick(input logic d_req, input logic i_req,
                                            input logic starved);
        arb_state_t pick;
        if (d_req && !starved) begin
            pick = ARB_DACC;
        end else if (i_req) begin
            pick = ARB_IACC;
        end else begin
            pick = ARB_IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM signal bundle for the memory arbiter
// The arb view is the arbiter side; the tb view drives requests and RAM responses.
interface mem_arbiter_if;

    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port RAM arbiter with starvation guard
// RAM strobes decode from the registered grant so a reset clears them at once.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT    = 15,
    parameter int STARVE_LIM = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] STARVE_C  = CNT_W'(STARVE_LIM);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             err_q, err_d;

    ramstate_t rs;
    logic      d_req;
    logic      granted;
    logic      access;
    logic      fault;
    logic      req_held;

    assign rs       = ramstate_t'(ramstate);
    assign d_req    = dREN | dWEN;
    assign granted  = (state_q != ARB_IDLE);
    assign access   = granted && (rs == RAM_ACCESS);
    assign fault    = granted && ((rs == RAM_ERROR) ||
                                  ((rs != RAM_ACCESS) && (wait_cnt_q == TIMEOUT_C)));
    assign req_held = (state_q == ARB_IACC) ? iREN : d_req;

    assign iload = ramload;
    assign dload = ramload;
    assign err   = err_q;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (access) begin
            if ((state_q == ARB_DACC) && iREN) begin
                starve_cnt_d = (starve_cnt_q >= STARVE_C) ? STARVE_C : starve_cnt_q + ONE_C;
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    // Re-arbitrate on completion with the updated starve count for back-to-back grants
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        err_d      = 1'b0;
        if (!granted || access) begin
            state_d = arb_pick(d_req, iREN, (starve_cnt_d == STARVE_C) && iREN);
        end else if (fault) begin
            state_d = ARB_IDLE;
            err_d   = 1'b1;
        end else if (!req_held) begin
            state_d = ARB_IDLE;
        end else begin
            wait_cnt_d = wait_cnt_q + ONE_C;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ARB_IDLE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

    // Write wins when the data side raises both strobes
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = d_req;
        unique case (state_q)
            ARB_IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = (rs != RAM_ACCESS);
            end
            ARB_DACC: begin
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = (rs != RAM_ACCESS);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Inputs change 2 time units after a rising edge; outputs are checked before the next edge.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic err;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] sv_exp [7];

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(15), .STARVE_LIM(4)) dut (
        .CLK      (clk),
        .RST      (rst),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .iload    (bus.iload),
        .iwait    (bus.iwait),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .dload    (bus.dload),
        .dwait    (bus.dwait),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.iREN     = 1'b1;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = RAM_FREE;
        repeat (2) tick;
        chk("rst_ren", bus.ramREN, 0);
        chk("rst_wen", bus.ramWEN, 0);
        chk("rst_addr", bus.ramaddr, 0);
        chk("rst_err", err, 0);
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_dwait", bus.dwait, 0);

        // single fetch: two BUSY cycles then ACCESS
        bus.iaddr    = 32'h40;
        bus.ramload  = 32'h1234_5678;
        bus.ramstate = RAM_BUSY;
        rst          = 1'b0;
        tick;
        chk("f_ren", bus.ramREN, 1);
        chk("f_addr", bus.ramaddr, 32'h40);
        chk("f_wait1", bus.iwait, 1);
        tick;
        chk("f_wait2", bus.iwait, 1);
        bus.ramstate = RAM_ACCESS;
        bus.iREN     = 1'b0;
        #1;
        chk("f_wait3", bus.iwait, 0);
        chk("f_iload", bus.iload, 32'h1234_5678);
        tick;
        bus.ramstate = RAM_FREE;
        #1;
        chk("f_idle", bus.ramREN, 0);

        // simultaneous requests: data first, instruction right after
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h44;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h100;
        bus.ramload  = 32'hCAFE_0001;
        bus.ramstate = RAM_BUSY;
        tick;
        chk("s_daddr", bus.ramaddr, 32'h100);
        chk("s_dren", bus.ramREN, 1);
        chk("s_iwait", bus.iwait, 1);
        chk("s_dwait1", bus.dwait, 1);
        bus.ramstate = RAM_ACCESS;
        bus.dREN     = 1'b0;
        #1;
        chk("s_dwait0", bus.dwait, 0);
        chk("s_dload", bus.dload, 32'hCAFE_0001);
        tick;
        chk("s_iaddr", bus.ramaddr, 32'h44);
        chk("s_iwait0", bus.iwait, 0);
        bus.iREN = 1'b0;
        tick;
        chk("s_idle", bus.ramREN, 0);

        // starvation: both data strobes held, single-cycle RAM, limit 4
        sv_exp = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h48, 32'h200, 32'h200};
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.dstore   = 32'hA5A5_A5A5;
        bus.daddr    = 32'h200;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h48;
        bus.ramstate = RAM_ACCESS;
        tick;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("sv_addr%0d", k), bus.ramaddr, sv_exp[k]);
            chk($sformatf("sv_wen%0d", k), bus.ramWEN, {31'b0, sv_exp[k] == 32'h200});
            chk($sformatf("sv_ren%0d", k), bus.ramREN, {31'b0, sv_exp[k] != 32'h200});
            chk($sformatf("sv_store%0d", k), bus.ramstore,
                (sv_exp[k] == 32'h200) ? 32'hA5A5_A5A5 : 32'h0);
            if (k == 6) begin
                bus.dREN = 1'b0;
                bus.dWEN = 1'b0;
                bus.iREN = 1'b0;
            end
            tick;
        end
        chk("sv_idle_ren", bus.ramREN, 0);
        chk("sv_idle_wen", bus.ramWEN, 0);

        // timeout: RAM stuck BUSY
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h4C;
        bus.ramstate = RAM_BUSY;
        tick;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("to_wait%0d", k), {30'b0, err, bus.ramREN}, 32'h1);
            tick;
        end
        chk("to_err", err, 1);
        chk("to_idle", bus.ramREN, 0);
        chk("to_iwait", bus.iwait, 1);
        tick;
        chk("to_pulse", err, 0);
        chk("to_retry", bus.ramREN, 1);
        bus.iREN = 1'b0;
        tick;
        chk("drop_err", err, 0);
        chk("drop_idle", bus.ramREN, 0);

        // RAM ERROR during a data access
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h300;
        bus.ramstate = RAM_BUSY;
        tick;
        chk("e_addr", bus.ramaddr, 32'h300);
        bus.ramstate = RAM_ERROR;
        #1;
        chk("e_dwait", bus.dwait, 1);
        tick;
        chk("e_err", err, 1);
        chk("e_dwait2", bus.dwait, 1);
        chk("e_idle", bus.ramREN, 0);
        bus.dREN     = 1'b0;
        bus.ramstate = RAM_FREE;
        tick;
        chk("e_pulse", err, 0);

        // reset in the middle of an instruction access
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h50;
        bus.ramstate = RAM_BUSY;
        tick;
        chk("r_pre", bus.ramREN, 1);
        rst = 1'b1;
        #1;
        chk("r_ren", bus.ramREN, 0);
        chk("r_addr", bus.ramaddr, 0);
        tick;
        chk("r_hold", bus.ramREN, 0);
        chk("r_iwait", bus.iwait, 1);
        rst = 1'b0;
        tick;
        chk("r_grant", bus.ramREN, 1);
        chk("r_gaddr", bus.ramaddr, 32'h50);
        bus.iREN = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
